// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - ID/EX hazard-control bundle between pipeline and stall unit
interface hazard_stall_unit_if #(
    parameter int STAT_WIDTH = 32
);
    logic                  id_valid;
    logic [4:0]            id_rs1;
    logic [4:0]            id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [4:0]            id_rd;
    logic                  id_RegWrite;
    logic                  id_is_mc;
    logic                  ex_valid;
    logic [4:0]            ex_rd;
    logic                  ex_MemRead;
    logic                  mc_start;
    logic [4:0]            mc_rd;
    logic                  ex_branch_taken;
    logic                  pc_write;
    logic                  if_id_write;
    logic                  id_ex_bubble;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  mc_busy;
    logic                  proto_err;
    logic [STAT_WIDTH-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_RegWrite,
               id_is_mc, ex_valid, ex_rd, ex_MemRead, mc_start, mc_rd, ex_branch_taken,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
               mc_busy, proto_err, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_RegWrite,
               id_is_mc, ex_valid, ex_rd, ex_MemRead, mc_start, mc_rd, ex_branch_taken,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
               mc_busy, proto_err, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / multi-cycle / branch-flush stall and flush control
module hazard_stall_unit #(
    parameter int MC_LATENCY = 4,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    hazard_stall_unit_if.slave    bus
);
    localparam logic [3:0] LAT = 4'(MC_LATENCY);

    logic [3:0]            r_cnt;
    logic [4:0]            r_pend_rd;
    logic                  r_pend_v;
    logic                  r_proto_err;
    logic [STAT_WIDTH-1:0] r_stall_cycles;

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_blocking;
    logic w_load_use;
    logic w_mc_raw;
    logic w_mc_waw;
    logic w_mc_struct;
    logic w_stall;

    // cnt == 1 means the result sits in MEM/WB and is forwarded, so only cnt >= 2 blocks
    assign w_blocking = (r_cnt >= 4'd2);
    assign w_rs1_hit  = bus.id_uses_rs1 && (bus.id_rs1 != 5'd0);
    assign w_rs2_hit  = bus.id_uses_rs2 && (bus.id_rs2 != 5'd0);

    assign w_load_use  = bus.id_valid && bus.ex_valid && bus.ex_MemRead && (bus.ex_rd != 5'd0) &&
                         ((w_rs1_hit && (bus.ex_rd == bus.id_rs1)) ||
                          (w_rs2_hit && (bus.ex_rd == bus.id_rs2)));
    assign w_mc_raw    = bus.id_valid && r_pend_v && w_blocking &&
                         ((w_rs1_hit && (r_pend_rd == bus.id_rs1)) ||
                          (w_rs2_hit && (r_pend_rd == bus.id_rs2)));
    assign w_mc_waw    = bus.id_valid && bus.id_RegWrite && r_pend_v && w_blocking &&
                         (bus.id_rd == r_pend_rd);
    assign w_mc_struct = bus.id_valid && bus.id_is_mc && w_blocking;
    assign w_stall     = w_load_use || w_mc_raw || w_mc_waw || w_mc_struct;

    always_comb begin
        bus.pc_write     = 1'b1;
        bus.if_id_write  = 1'b1;
        bus.id_ex_bubble = 1'b0;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_flush  = 1'b0;
        if (bus.ex_branch_taken) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (w_stall) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_bubble = 1'b1;
        end
    end

    assign bus.mc_busy      = (r_cnt != 4'd0);
    assign bus.proto_err    = r_proto_err;
    assign bus.stall_cycles = r_stall_cycles;

    // Flush leaves the scoreboard alone: the in-flight op is older than the branch
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt          <= 4'd0;
            r_pend_rd      <= 5'd0;
            r_pend_v       <= 1'b0;
            r_proto_err    <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            if (bus.mc_start && !w_blocking) begin
                r_cnt     <= LAT;
                r_pend_rd <= bus.mc_rd;
                r_pend_v  <= (bus.mc_rd != 5'd0);
            end else begin
                if (bus.mc_start) begin
                    r_proto_err <= 1'b1;
                end
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end
                if (r_cnt == 4'd1) begin
                    r_pend_v <= 1'b0;
                end
            end
            if (w_stall && !bus.ex_branch_taken && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end
endmodule
